// File: rtl/clut_fill_if.sv
// Bus bundle between the CLUT fill controller and its surroundings: texel lookup
// ports, VRAM burst read port and the cache write port.
interface clut_fill_if #(
  parameter int ADDR_W = 18
);
  logic [15:0]       i_clutId;
  logic              i_lookupVld1;
  logic [7:0]        i_readIdx1;
  logic              i_isHit1;
  logic              i_lookupVld2;
  logic [7:0]        i_readIdx2;
  logic              i_isHit2;
  logic              o_stall;
  logic              o_memReq;
  logic [ADDR_W-1:0] o_memAddr;
  logic              i_memAck;
  logic              i_memValid;
  logic [31:0]       i_memData;
  logic              o_write;
  logic [6:0]        o_writeIdx;
  logic [31:0]       o_colorIn;

  modport master (
    input  i_clutId, i_lookupVld1, i_readIdx1, i_isHit1,
           i_lookupVld2, i_readIdx2, i_isHit2,
           i_memAck, i_memValid, i_memData,
    output o_stall, o_memReq, o_memAddr, o_write, o_writeIdx, o_colorIn
  );

  modport slave (
    output i_clutId, i_lookupVld1, i_readIdx1, i_isHit1,
           i_lookupVld2, i_readIdx2, i_isHit2,
           i_memAck, i_memValid, i_memData,
    input  o_stall, o_memReq, o_memAddr, o_write, o_writeIdx, o_colorIn
  );
endinterface

// File: rtl/clut_fill_ctrl.sv
// CLUT cache miss handler: detects a lookup miss, fetches the 16-colour block from
// VRAM as an 8-word burst and streams it into the cache, stalling the texel pipe.
module clut_fill_ctrl #(
  parameter int ADDR_W    = 18,
  parameter int BURST_LEN = 8
) (
  input  logic         clk,
  input  logic         i_rst,
  clut_fill_if.master  bus
);
  localparam int BEAT_W = $clog2(BURST_LEN);

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_FILL, S_DONE, S_DRAIN} state_t;

  state_t              r_state, w_next;
  logic [3:0]          r_blk;
  logic [14:0]         r_clutId;
  logic [BEAT_W-1:0]   r_beat;
  logic                r_abort;
  logic [ADDR_W-1:0]   r_memAddr;
  logic                r_write;
  logic [6:0]          r_writeIdx;
  logic [31:0]         r_colorIn;

  logic                w_miss1, w_miss2, w_missAny, w_cidChg, w_lastBeat, w_beatIn;
  logic [3:0]          w_blkNext;
  logic [9:0]          w_col;
  logic                w_unused;

  assign w_miss1    = bus.i_lookupVld1 & ~bus.i_isHit1;
  assign w_miss2    = bus.i_lookupVld2 & ~bus.i_isHit2;
  assign w_missAny  = w_miss1 | w_miss2;
  assign w_blkNext  = w_miss1 ? bus.i_readIdx1[7:4] : bus.i_readIdx2[7:4];
  // 10-bit sum wraps the block column within the VRAM line
  assign w_col      = {bus.i_clutId[5:0], 4'b0} + {2'b0, w_blkNext, 4'b0};
  assign w_cidChg   = bus.i_clutId[14:0] != r_clutId;
  assign w_lastBeat = r_beat == BEAT_W'(BURST_LEN - 1);
  assign w_beatIn   = bus.i_memValid & w_lastBeat;
  assign w_unused   = ^{bus.i_clutId[15], bus.i_readIdx1[3:0], bus.i_readIdx2[3:0]};

  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_missAny) w_next = S_REQ;
      S_REQ:   if (bus.i_memAck) w_next = (r_abort | w_cidChg) ? S_DRAIN : S_FILL;
      // a CLUT change on the final beat has nothing left to drain
      S_FILL:  if (w_cidChg)     w_next = w_beatIn ? S_IDLE : S_DRAIN;
               else if (w_beatIn) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      S_DRAIN: if (w_beatIn) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    bus.o_stall  = r_state != S_IDLE;
    bus.o_memReq = r_state == S_REQ;
  end

  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      r_blk      <= '0;
      r_clutId   <= '0;
      r_beat     <= '0;
      r_abort    <= 1'b0;
      r_memAddr  <= '0;
      r_write    <= 1'b0;
      r_writeIdx <= '0;
      r_colorIn  <= '0;
    end else begin
      r_write <= 1'b0;
      case (r_state)
        S_IDLE: if (w_missAny) begin
          r_blk     <= w_blkNext;
          r_clutId  <= bus.i_clutId[14:0];
          r_memAddr <= ADDR_W'({bus.i_clutId[14:6], w_col[9:1]});
          r_abort   <= 1'b0;
        end
        S_REQ: begin
          if (w_cidChg)     r_abort <= 1'b1;
          if (bus.i_memAck) r_beat  <= '0;
        end
        S_FILL, S_DRAIN: if (bus.i_memValid) begin
          r_beat <= r_beat + 1'b1;
          if (r_state == S_FILL && !w_cidChg) begin
            r_write    <= 1'b1;
            r_writeIdx <= 7'({r_blk, r_beat});
            r_colorIn  <= bus.i_memData;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.o_memAddr  = r_memAddr;
  assign bus.o_write    = r_write;
  assign bus.o_writeIdx = r_writeIdx;
  assign bus.o_colorIn  = r_colorIn;
endmodule
